// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive front end.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam int FRAME_BITS = 8;

  // Active-low gfedcba patterns, index = hex digit.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/ps2_rx_interface_if.sv
// PS/2 pin and received-byte bundle.
interface ps2_rx_if;

  logic       ps2_clock;
  logic       ps2_data;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic [7:0] ps2_out;
  logic       frame_error;

  modport master (
    output ps2_clock,
    output ps2_data,
    input  ps2_key_data,
    input  ps2_key_pressed,
    input  ps2_out,
    input  frame_error
  );

  modport slave (
    input  ps2_clock,
    input  ps2_data,
    output ps2_key_data,
    output ps2_key_pressed,
    output ps2_out,
    output frame_error
  );

endinterface

// File: rtl/hex_seg_decoder.sv
// One hex digit to active-low gfedcba seven-segment pattern.
module hex_seg_decoder
  import ps2_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[hex_i];

endmodule

// File: rtl/ps2_rx_interface.sv
// PS/2 keyboard receiver: sync, deglitch, 11-bit frame deserializer.
// Define PS2_SEG_EN to add seg_lo/seg_hi hex digit outputs.
module ps2_rx_interface
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  ps2_rx_if.slave    bus
`ifdef PS2_SEG_EN
  ,
  output logic [6:0] seg_lo,
  output logic [6:0] seg_hi
`endif
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(FRAME_BITS);

  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic          fprev_q;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;

  ps2_state_e    state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tout_q, tout_d;
  logic          kp_q, kp_d;
  logic          err_q, err_d;
  logic [7:0]    kd_q, kd_d;
  logic [7:0]    out_q, out_d;

  // Level change only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1))
        filt_d = clk_s2_q;
      else
        fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign fall = fprev_q & ~filt_q;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    tout_d  = '0;
    kp_d    = 1'b0;
    err_d   = 1'b0;
    kd_d    = kd_q;
    out_d   = out_q;
    if (state_q != IDLE && !fall)
      tout_d = tout_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (fall && !dat_s2_q) begin
          state_d = DATA;
          bcnt_d  = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == BW'(FRAME_BITS - 1))
            state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (dat_s2_q && (^{shift_q, par_q})) begin
            kp_d  = 1'b1;
            kd_d  = shift_q;
            out_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (tout_d == TW'(TIMEOUT_CYCLES)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      tout_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fprev_q  <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= IDLE;
      bcnt_q   <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tout_q   <= '0;
      kp_q     <= 1'b0;
      err_q    <= 1'b0;
      kd_q     <= '0;
      out_q    <= '0;
    end else begin
      clk_s1_q <= bus.ps2_clock;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= bus.ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fprev_q  <= filt_q;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tout_q   <= tout_d;
      kp_q     <= kp_d;
      err_q    <= err_d;
      kd_q     <= kd_d;
      out_q    <= out_d;
    end
  end

  assign bus.ps2_key_data    = kd_q;
  assign bus.ps2_key_pressed = kp_q;
  assign bus.ps2_out         = out_q;
  assign bus.frame_error     = err_q;

`ifdef PS2_SEG_EN
  hex_seg_decoder u_seg_lo (
    .hex_i (out_q[3:0]),
    .seg_o (seg_lo)
  );

  hex_seg_decoder u_seg_hi (
    .hex_i (out_q[7:4]),
    .seg_o (seg_hi)
  );
`endif

endmodule

// File: tb/tb_ps2_rx_interface.sv
// Self-checking bench for ps2_rx_interface with a frame-level model.
`timescale 1ns/1ps
module tb_ps2_rx_interface;

  localparam int FL = 8;
  localparam int TO = 200;
  localparam int H  = 20;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   proto_bad = 0;
  int   last_fall = 0;
  logic kp_prev = 1'b0;
  logic [7:0] exp_out = 8'h00;

  typedef struct {
    bit         err;
    logic [7:0] kd;
    logic [7:0] po;
    int         cyc;
  } ev_t;
  ev_t ev_q[$];

  ps2_rx_if bus ();

`ifdef PS2_SEG_EN
  logic [6:0] seg_lo, seg_hi;
  logic [6:0] seg_tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
`endif

  ps2_rx_interface #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock  (clk),
    .reset  (reset),
    .bus    (bus)
`ifdef PS2_SEG_EN
    ,
    .seg_lo (seg_lo),
    .seg_hi (seg_hi)
`endif
  );

  initial forever #1000 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ps2_key_pressed)
      ev_q.push_back('{1'b0, bus.ps2_key_data, bus.ps2_out, cyc});
    if (bus.frame_error)
      ev_q.push_back('{1'b1, bus.ps2_key_data, bus.ps2_out, cyc});
    if (bus.ps2_key_pressed && bus.frame_error) proto_bad++;
    if (bus.ps2_key_pressed && kp_prev) proto_bad++;
    kp_prev = bus.ps2_key_pressed;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_edge(bit b);
    bus.ps2_data = b;
    tick(H);
    bus.ps2_clock = 1'b0;
    last_fall = cyc;
    tick(H);
    bus.ps2_clock = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] d, bit par, bit stp);
    ps2_edge(1'b0);
    for (int i = 0; i < 8; i++) ps2_edge(d[i]);
    ps2_edge(par);
    ps2_edge(stp);
    bus.ps2_data = 1'b1;
  endtask

  function automatic bit model_valid(logic [7:0] d, bit par, bit stp);
    return stp && ((($countones(d) + int'(par)) % 2) == 1);
  endfunction

  task automatic test_reset;
    total++;
    if (bus.ps2_key_data !== 8'h00) $display("FAIL reset_kd: got %h want 00", bus.ps2_key_data);
    else passed++;
    total++;
    if (bus.ps2_key_pressed !== 1'b0) $display("FAIL reset_kp: got %b want 0", bus.ps2_key_pressed);
    else passed++;
    total++;
    if (bus.ps2_out !== 8'h00) $display("FAIL reset_out: got %h want 00", bus.ps2_out);
    else passed++;
    total++;
    if (bus.frame_error !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.frame_error);
    else passed++;
`ifdef PS2_SEG_EN
    total++;
    if ({seg_hi, seg_lo} !== {7'h40, 7'h40})
      $display("FAIL reset_seg: got %h/%h want 40/40", seg_hi, seg_lo);
    else passed++;
`endif
  endtask

  task automatic test_valid_1c;
    ev_q.delete();
    send_frame(8'h1C, 1'b0, 1'b1);
    exp_out = 8'h1C;
    total++;
    if (ev_q.size() != 1) $display("FAIL valid_count: got %0d want 1", ev_q.size());
    else passed++;
    if (ev_q.size() > 0) begin
      total++;
      if (ev_q[0].err || ev_q[0].kd !== 8'h1C)
        $display("FAIL valid_kd: got err=%b %h want err=0 1c", ev_q[0].err, ev_q[0].kd);
      else passed++;
      total++;
      if (ev_q[0].po !== 8'h1C) $display("FAIL valid_out: got %h want 1c", ev_q[0].po);
      else passed++;
      total++;
      if (ev_q[0].cyc - last_fall != FL + 3)
        $display("FAIL valid_latency: got %0d want %0d", ev_q[0].cyc - last_fall, FL + 3);
      else passed++;
    end
    total++;
    if (bus.ps2_out !== exp_out) $display("FAIL valid_hold: got %h want %h", bus.ps2_out, exp_out);
    else passed++;
`ifdef PS2_SEG_EN
    total++;
    if (seg_lo !== seg_tbl[exp_out[3:0]] || seg_hi !== seg_tbl[exp_out[7:4]])
      $display("FAIL valid_seg: got %h/%h want 79/46", seg_hi, seg_lo);
    else passed++;
`endif
  endtask

  task automatic test_back_to_back;
    ev_q.delete();
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    exp_out = 8'h1C;
    total++;
    if (ev_q.size() != 2) $display("FAIL b2b_count: got %0d want 2", ev_q.size());
    else passed++;
    if (ev_q.size() == 2) begin
      total++;
      if (ev_q[0].err || ev_q[0].po !== 8'hF0)
        $display("FAIL b2b_first: got err=%b %h want err=0 f0", ev_q[0].err, ev_q[0].po);
      else passed++;
      total++;
      if (ev_q[1].err || ev_q[1].po !== 8'h1C)
        $display("FAIL b2b_second: got err=%b %h want err=0 1c", ev_q[1].err, ev_q[1].po);
      else passed++;
    end
  endtask

  task automatic test_parity_error;
    send_frame(8'h33, ~^8'h33, 1'b1);
    exp_out = 8'h33;
    ev_q.delete();
    send_frame(8'h1C, 1'b1, 1'b1);
    total++;
    if (ev_q.size() != 1 || !ev_q[0].err)
      $display("FAIL parity_err: got %0d events want 1 error", ev_q.size());
    else passed++;
    total++;
    if (bus.ps2_out !== exp_out) $display("FAIL parity_hold: got %h want %h", bus.ps2_out, exp_out);
    else passed++;
  endtask

  task automatic test_timeout;
    ev_q.delete();
    ps2_edge(1'b0);
    for (int i = 0; i < 4; i++) ps2_edge(1'b1);
    bus.ps2_data = 1'b1;
    tick(TO + 60);
    total++;
    if (ev_q.size() != 1 || !ev_q[0].err)
      $display("FAIL timeout_err: got %0d events want 1 error", ev_q.size());
    else passed++;
    ev_q.delete();
    send_frame(8'h5A, ~^8'h5A, 1'b1);
    exp_out = 8'h5A;
    total++;
    if (ev_q.size() != 1 || ev_q[0].err || ev_q[0].kd !== 8'h5A)
      $display("FAIL timeout_recover: got %0d events kd=%h want 1 strobe 5a",
               ev_q.size(), bus.ps2_key_data);
    else passed++;
  endtask

  task automatic test_glitch;
    ev_q.delete();
    bus.ps2_data = 1'b0;
    tick(H);
    bus.ps2_clock = 1'b0;
    tick(3);
    bus.ps2_clock = 1'b1;
    tick(2 * H);
    bus.ps2_data = 1'b1;
    total++;
    if (ev_q.size() != 0) $display("FAIL glitch_quiet: got %0d events want 0", ev_q.size());
    else passed++;
    ps2_edge(1'b1);
    tick(2 * H);
    total++;
    if (ev_q.size() != 0) $display("FAIL badstart_quiet: got %0d events want 0", ev_q.size());
    else passed++;
    send_frame(8'h4B, ~^8'h4B, 1'b1);
    exp_out = 8'h4B;
    total++;
    if (ev_q.size() != 1 || ev_q[0].err || ev_q[0].kd !== 8'h4B)
      $display("FAIL glitch_recover: got %0d events out=%h want 1 strobe 4b",
               ev_q.size(), bus.ps2_out);
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [7:0] d = 8'h29;
    ev_q.delete();
    ps2_edge(1'b0);
    for (int i = 0; i < 5; i++) ps2_edge(d[i]);
    bus.ps2_data = d[5];
    tick(H / 2);
    reset = 1'b1;
    tick(1);
    exp_out = 8'h00;
    total++;
    if ({bus.ps2_key_data, bus.ps2_out, bus.ps2_key_pressed, bus.frame_error} !== 18'h0)
      $display("FAIL midreset_zero: got kd=%h out=%h want 00/00", bus.ps2_key_data, bus.ps2_out);
    else passed++;
    reset = 1'b0;
    bus.ps2_data = 1'b1;
    tick(2 * H);
    ev_q.delete();
    send_frame(d, ~^d, 1'b1);
    exp_out = d;
    total++;
    if (ev_q.size() != 1 || ev_q[0].err || ev_q[0].kd !== 8'h29)
      $display("FAIL midreset_recover: got %0d events out=%h want 1 strobe 29",
               ev_q.size(), bus.ps2_out);
    else passed++;
  endtask

  task automatic test_random;
    for (int n = 0; n < 14; n++) begin
      logic [7:0] d;
      bit par, stp, ok;
      int mode;
      d = 8'($urandom);
      mode = $urandom_range(0, 3);
      par = (mode == 1) ? ^d : ~^d;
      stp = (mode != 2);
      ok = model_valid(d, par, stp);
      if (ok) exp_out = d;
      ev_q.delete();
      send_frame(d, par, stp);
      tick(2);
      total++;
      if (ev_q.size() != 1 || ev_q[0].err == ok || ev_q[0].po !== exp_out)
        $display("FAIL random_%0d: got %0d events out=%h want valid=%b out=%h",
                 n, ev_q.size(), bus.ps2_out, ok, exp_out);
      else passed++;
    end
  endtask

  task automatic test_protocol;
    total++;
    if (proto_bad != 0) $display("FAIL strobe_protocol: got %0d violations want 0", proto_bad);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    bus.ps2_clock = 1'b1;
    bus.ps2_data = 1'b1;
    tick(4);
    test_reset;
    reset = 1'b0;
    tick(4);
    test_valid_1c;
    test_back_to_back;
    test_parity_error;
    test_timeout;
    test_glitch;
    test_reset_mid;
    test_random;
    test_protocol;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
